// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller: access size codes, FSM state encoding
// and the access-legality rule used when a request is accepted.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        ACK    = 2'b11
    } state_t;

    localparam int WAIT_WIDTH = 4;

    // Halfwords must start on an even byte; the 11 size code is never legal.
    function automatic logic is_illegal(input logic [1:0] size, input logic odd_sel);
        return (size == SIZE_ILLEGAL) || ((size == SIZE_HALF) && odd_sel);
    endfunction

endpackage

// File: rtl/byte_lane.sv
// Lane steering between a big-endian memory word (byte 0 = bits 0:7) and right-justified
// CPU data: extracts the addressed lane for loads and merges store data for partial stores.
module byte_lane
    import mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic [0:1]  byte_sel,
    input  logic [0:31] mem_word,
    input  logic [0:31] store_data,
    output logic [0:31] load_data,
    output logic [0:31] merged_word
);

    always_comb begin
        load_data   = '0;
        merged_word = mem_word;
        case (size)
            SIZE_BYTE: begin
                for (int n = 0; n < 4; n++) begin
                    if (byte_sel == 2'(n)) begin
                        load_data[24:31]      = mem_word[8*n +: 8];
                        merged_word[8*n +: 8] = store_data[24:31];
                    end
                end
            end
            SIZE_HALF: begin
                if (byte_sel[0]) begin
                    load_data[16:31]   = mem_word[16:31];
                    merged_word[16:31] = store_data[16:31];
                end else begin
                    load_data[16:31]  = mem_word[0:15];
                    merged_word[0:15] = store_data[16:31];
                end
            end
            SIZE_WORD: begin
                load_data   = mem_word;
                merged_word = store_data;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_control.sv
// CPU-to-RAM bridge for byte/halfword/word loads and stores with optional wait states;
// partial stores are done as a read-modify-write through the byte_lane merger.
module mem_control
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req,
    input  logic         wr,
    input  logic [1:0]   size,
    input  logic [15:31] address,
    input  logic [0:1]   byte_sel,
    input  logic [0:31]  wdata,
    output logic [0:31]  rdata,
    output logic         ack,
    output logic         error,
    output logic         busy,
    output logic [15:31] mem_address,
    output logic         mem_write_en,
    output logic [0:31]  mem_data_out,
    input  logic [0:31]  mem_data_in
);

    localparam logic [WAIT_WIDTH-1:0] WAIT_INIT = WAIT_WIDTH'(WAIT_STATES);

    state_t                state;
    state_t                next_state;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  lat_wr;
    mem_size_t             lat_size;
    logic [0:1]            lat_byte_sel;
    logic                  lat_error;
    logic [0:31]           load_data;
    logic [0:31]           merged_word;
    logic                  accept;
    logic                  illegal;
    logic                  wait_done;
    logic                  partial_store;

    assign accept        = (state == IDLE) && req;
    assign illegal       = is_illegal(size, byte_sel[1]);
    assign wait_done     = (wait_cnt == '0);
    assign partial_store = lat_wr && (lat_size != SIZE_WORD);

    // mem_data_out holds the store data until the merge overwrites it with the full word.
    byte_lane u_byte_lane (
        .size        (lat_size),
        .byte_sel    (lat_byte_sel),
        .mem_word    (mem_data_in),
        .store_data  (mem_data_out),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = illegal ? ACK : ACCESS;
            ACCESS:  if (wait_done) next_state = partial_store ? WRITE : ACK;
            WRITE:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ack          = (state == ACK);
        error        = (state == ACK) && lat_error;
        busy         = (state != IDLE);
        mem_write_en = (state == WRITE) ||
                       ((state == ACCESS) && wait_done && lat_wr && (lat_size == SIZE_WORD));
    end

    // Illegal requests never touch mem_address or mem_data_out, so no RAM access follows.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt     <= '0;
            lat_wr       <= 1'b0;
            lat_size     <= SIZE_BYTE;
            lat_byte_sel <= '0;
            lat_error    <= 1'b0;
            mem_address  <= '0;
            mem_data_out <= '0;
            rdata        <= '0;
        end else if (accept) begin
            wait_cnt     <= WAIT_INIT;
            lat_wr       <= wr;
            lat_size     <= mem_size_t'(size);
            lat_byte_sel <= byte_sel;
            lat_error    <= illegal;
            if (!illegal) begin
                mem_address <= address;
                if (wr) begin
                    mem_data_out <= wdata;
                end
            end
        end else if (state == ACCESS) begin
            if (!wait_done) begin
                wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
            end else if (!lat_wr) begin
                rdata <= load_data;
            end else if (partial_store) begin
                mem_data_out <= merged_word;
            end
        end
    end

endmodule
